// File: rtl/pwm_pkg.sv
// Purpose: shared types and constants for the PWM fade sequencer slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RAMP  = 3'd1,
    HOLD  = 3'd2,
    BR_UP = 3'd3,
    BR_DN = 3'd4
  } state_t;

  localparam logic MODE_RAMP    = 1'b0;
  localparam logic MODE_BREATHE = 1'b1;

endpackage

// File: rtl/pwm_fade_ctrl_if.sv
// Purpose: load/ready handshake plus program payload (target, rate, mode).
// Latency: n/a (wires only).
// Backpressure: master holds load until sampled with ready high.
// Ports: master = register/control layer, slave = pwm_fade_ctrl.
interface pwm_fade_ctrl_if #(
  parameter int N = 8
);
  logic         load;
  logic         ready;
  logic [N-1:0] target;
  logic [N-1:0] rate;
  logic         mode;

  modport master (output load, target, rate, mode, input ready);
  modport slave  (input load, target, rate, mode, output ready);
endinterface

// File: rtl/pwm.sv
// Purpose: minimal PWM datapath: output high for the first duty steps of each period.
// Latency: output is combinational from the step counter and duty.
// Backpressure: none.
// Ports: clk, rst (async active-low), step, duty in; pwm_out out.
module pwm #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic [N-1:0] duty,
  output logic         pwm_out
);

  logic [N-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign pwm_out = (cnt < duty);

endmodule

// File: rtl/pwm_tick_gen.sv
// Purpose: prescaler producing the PWM step tick, plus the N-bit step counter.
// Latency: step registered, one pulse per prescale+1 enabled cycles.
// Backpressure: none; ena low freezes all counters and masks pulses.
// Ports: clk, rst (async active-low), ena, prescale in; step, period_end out.
module pwm_tick_gen #(
  parameter int PRESCALE_W = 16,
  parameter int N          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  step,
  output logic                  period_end
);

  logic [PRESCALE_W-1:0] pre_cnt;
  logic [N-1:0]          step_cnt;
  logic                  step_q;

  // Everything is held (not cleared) while ena is low, so a pending step
  // survives a disable window and timing resumes exactly where it stopped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
      step_q   <= 1'b0;
    end else if (ena) begin
      if (step_q) begin
        step_cnt <= step_cnt + 1'b1;
      end
      if (pre_cnt == prescale) begin
        step_q  <= 1'b1;
        pre_cnt <= '0;
      end else if (pre_cnt > prescale) begin
        // prescale shrank below the running count: wrap silently
        step_q  <= 1'b0;
        pre_cnt <= '0;
      end else begin
        step_q  <= 1'b0;
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

  assign step       = step_q & ena;
  assign period_end = step & (step_cnt == {N{1'b1}});

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Purpose: sequences pwm duty: ramp-to-target or triangle breathe, updated at period ends.
// Latency: duty/done registered, new duty visible the cycle after period_end.
// Backpressure: ready low while ramping; loads seen with ready low are dropped.
// Ports: clk, rst (async active-low), ena, prescale, cfg (slave: load/ready/target/rate/mode);
//        step, duty, period_end, done out.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int N          = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [PRESCALE_W-1:0] prescale,
  pwm_fade_ctrl_if.slave        cfg,
  output logic                  step,
  output logic [N-1:0]          duty,
  output logic                  period_end,
  output logic                  done
);

  state_t       state;
  logic [N-1:0] duty_q;
  logic [N-1:0] tgt_q;
  logic [N-1:0] rate_q;
  logic         mode_q;
  logic         done_q;
  logic         accept;

  logic [N-1:0] amt;
  logic [N:0]   d_x, t_x, r_x, a_x;
  logic [N-1:0] ramp_nx, up_nx, dn_nx;

  pwm_tick_gen #(
    .PRESCALE_W (PRESCALE_W),
    .N          (N)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .prescale   (prescale),
    .step       (step),
    .period_end (period_end)
  );

  assign cfg.ready = (state != RAMP);
  assign accept    = cfg.load & cfg.ready;

  // Breathe never stalls: a zero rate still moves by one per period.
  assign amt = (mode_q == MODE_BREATHE && rate_q == '0) ? {{(N-1){1'b0}}, 1'b1} : rate_q;

  // One extra bit of headroom so sums/differences saturate instead of wrapping.
  assign d_x = {1'b0, duty_q};
  assign t_x = {1'b0, tgt_q};
  assign r_x = {1'b0, rate_q};
  assign a_x = {1'b0, amt};

  always_comb begin
    ramp_nx = tgt_q;
    up_nx   = tgt_q;
    dn_nx   = '0;
    if (rate_q != '0) begin
      if (duty_q < tgt_q) begin
        if (d_x + r_x < t_x) ramp_nx = duty_q + rate_q;
      end else if (duty_q > tgt_q) begin
        if (d_x - t_x > r_x) ramp_nx = duty_q - rate_q;
      end
    end
    if (d_x + a_x < t_x) up_nx = duty_q + amt;
    if (d_x > a_x)       dn_nx = duty_q - amt;
  end

  // A load takes priority over a coincident period_end: no update that cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      duty_q <= '0;
      tgt_q  <= '0;
      rate_q <= '0;
      mode_q <= MODE_RAMP;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        tgt_q  <= cfg.target;
        rate_q <= cfg.rate;
        mode_q <= cfg.mode;
        state  <= (cfg.mode == MODE_RAMP) ? RAMP : BR_UP;
      end else if (period_end) begin
        case (state)
          RAMP: begin
            duty_q <= ramp_nx;
            if (ramp_nx == tgt_q) begin
              state  <= HOLD;
              done_q <= 1'b1;
            end
          end
          BR_UP: begin
            duty_q <= up_nx;
            if (up_nx == tgt_q) state <= BR_DN;
          end
          BR_DN: begin
            duty_q <= dn_nx;
            if (dn_nx == '0) state <= BR_UP;
          end
          default: ;
        endcase
      end
    end
  end

  assign duty = duty_q;
  assign done = done_q & ena;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Purpose: directed end-to-end bench for pwm_fade_ctrl driving a pwm instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_fade_ctrl;

  localparam int N  = 8;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ena = 1'b0;
  logic [PW-1:0] prescale = '0;
  logic          step, period_end, done, pwm_out;
  logic [N-1:0]  duty;

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;

  pwm_fade_ctrl_if #(.N(N)) bus ();

  pwm_fade_ctrl #(.N(N), .PRESCALE_W(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .prescale   (prescale),
    .cfg        (bus),
    .step       (step),
    .duty       (duty),
    .period_end (period_end),
    .done       (done)
  );

  pwm #(.N(N)) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .step    (step),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic wait_pe(output int t);
    t = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (period_end === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++; n_err++;
      $display("FAIL wait_pe: period_end not seen within 2000 cycles");
    end
  endtask

  task automatic wait_step(output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (step === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_cmp++; n_err++;
      $display("FAIL wait_step: step not seen within 20 cycles");
    end
  endtask

  // Presents one load for one cycle; starts and ends on a negedge.
  task automatic do_load(input logic [N-1:0] tg, input logic [N-1:0] rt, input logic md);
    bus.load   = 1'b1;
    bus.target = tg;
    bus.rate   = rt;
    bus.mode   = md;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; ena = 1'b0; prescale = '0;
    bus.load = 1'b0; bus.target = '0; bus.rate = '0; bus.mode = 1'b0;
    #23;
    n_cmp++; if (duty !== 8'd0)       begin n_err++; $display("FAIL reset_duty: got %0d want 0", duty); end
    n_cmp++; if (bus.ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    n_cmp++; if (step !== 1'b0)       begin n_err++; $display("FAIL reset_step: got %b want 0", step); end
    n_cmp++; if (period_end !== 1'b0) begin n_err++; $display("FAIL reset_pe: got %b want 0", period_end); end
    n_cmp++; if (done !== 1'b0)       begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    @(negedge clk);
    rst = 1'b1; ena = 1'b1; prescale = 16'd3;
  endtask

  task automatic test_prescale;
    int start, t0, t1, p0, p1;
    start = cyc;
    wait_step(t0);
    n_cmp++; if (t0 - start != 4) begin n_err++; $display("FAIL first_step: got %0d cycles want 4", t0 - start); end
    wait_step(t1);
    n_cmp++; if (t1 - t0 != 4) begin n_err++; $display("FAIL step_spacing: got %0d want 4", t1 - t0); end
    wait_pe(p0);
    n_cmp++; if (p0 - start != 1024) begin n_err++; $display("FAIL first_pe: got %0d want 1024", p0 - start); end
    wait_pe(p1);
    n_cmp++; if (p1 - p0 != 1024) begin n_err++; $display("FAIL pe_spacing: got %0d want 1024", p1 - p0); end
    n_cmp++; if (duty !== 8'd0) begin n_err++; $display("FAIL idle_duty: got %0d want 0", duty); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", bus.ready); end
  endtask

  task automatic test_ramp_up;
    int exp_d[4] = '{30, 60, 90, 100};
    int t, d0, hi;
    do_load(8'd100, 8'd30, 1'b0);
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL ramp_ready_low: got %b want 0", bus.ready); end
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      wait_pe(t);
      @(negedge clk);
      n_cmp++; if (duty !== exp_d[i][N-1:0]) begin n_err++; $display("FAIL ramp_up_duty[%0d]: got %0d want %0d", i, duty, exp_d[i]); end
      n_cmp++; if (done !== (i == 3)) begin n_err++; $display("FAIL ramp_up_done[%0d]: got %b want %b", i, done, (i == 3)); end
    end
    @(negedge clk);
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL hold_ready: got %b want 1", bus.ready); end
    n_cmp++; if (done_cnt - d0 != 1) begin n_err++; $display("FAIL ramp_done_count: got %0d want 1", done_cnt - d0); end
    // pwm high-step count across one full period at duty 100
    hi = 0;
    for (int i = 0; i < 1100; i++) begin
      if (step === 1'b1 && pwm_out === 1'b1) hi++;
      if (period_end === 1'b1) break;
      @(negedge clk);
    end
    n_cmp++; if (hi != 100) begin n_err++; $display("FAIL pwm_high_steps: got %0d want 100", hi); end
  endtask

  task automatic test_ramp_down_rate0;
    int t;
    @(negedge clk);
    do_load(8'd10, 8'd0, 1'b0);
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL rd_ready_low: got %b want 0", bus.ready); end
    wait_pe(t);
    @(negedge clk);
    n_cmp++; if (duty !== 8'd10)     begin n_err++; $display("FAIL rd_duty: got %0d want 10", duty); end
    n_cmp++; if (done !== 1'b1)      begin n_err++; $display("FAIL rd_done: got %b want 1", done); end
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL rd_ready_high: got %b want 1", bus.ready); end
  endtask

  task automatic test_ena_gating;
    int t1, t2, t, bad;
    do_load(8'd200, 8'd50, 1'b0);
    do_load(8'd0, 8'd0, 1'b1);  // ready is low: must be dropped
    n_cmp++; if (bus.ready !== 1'b0) begin n_err++; $display("FAIL ign_ready: got %b want 0", bus.ready); end
    wait_pe(t1);
    @(negedge clk);
    n_cmp++; if (duty !== 8'd60) begin n_err++; $display("FAIL ign_duty: got %0d want 60", duty); end
    repeat (100) @(negedge clk);
    ena = 1'b0;
    bad = 0;
    repeat (500) begin
      @(negedge clk);
      if (step !== 1'b0 || period_end !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL ena_pulses: got %0d pulses want 0", bad); end
    n_cmp++; if (duty !== 8'd60) begin n_err++; $display("FAIL ena_frozen: got %0d want 60", duty); end
    ena = 1'b1;
    wait_pe(t2);
    n_cmp++; if (t2 - t1 != 1524) begin n_err++; $display("FAIL ena_resume: got %0d cycles want 1524", t2 - t1); end
    @(negedge clk);
    n_cmp++; if (duty !== 8'd110) begin n_err++; $display("FAIL ena_duty110: got %0d want 110", duty); end
    wait_pe(t);
    @(negedge clk);
    n_cmp++; if (duty !== 8'd160) begin n_err++; $display("FAIL ena_duty160: got %0d want 160", duty); end
    wait_pe(t);
    @(negedge clk);
    n_cmp++; if (duty !== 8'd200) begin n_err++; $display("FAIL ena_duty200: got %0d want 200", duty); end
    n_cmp++; if (done !== 1'b1)   begin n_err++; $display("FAIL ena_done: got %b want 1", done); end
  endtask

  task automatic test_breathe;
    int exp_d[9] = '{64, 128, 192, 255, 191, 127, 63, 0, 64};
    int t;
    do_load(8'd0, 8'd0, 1'b0);
    wait_pe(t);
    @(negedge clk);
    n_cmp++; if (duty !== 8'd0) begin n_err++; $display("FAIL br_zero: got %0d want 0", duty); end
    do_load(8'd255, 8'd64, 1'b1);
    n_cmp++; if (bus.ready !== 1'b1) begin n_err++; $display("FAIL br_ready: got %b want 1", bus.ready); end
    for (int i = 0; i < 9; i++) begin
      wait_pe(t);
      @(negedge clk);
      n_cmp++; if (duty !== exp_d[i][N-1:0]) begin n_err++; $display("FAIL br_duty[%0d]: got %0d want %0d", i, duty, exp_d[i]); end
    end
  endtask

  task automatic test_load_at_pe;
    int t;
    repeat (1023) @(negedge clk);
    n_cmp++; if (period_end !== 1'b1) begin n_err++; $display("FAIL lpe_align: got %b want 1", period_end); end
    do_load(8'd255, 8'd10, 1'b1);
    n_cmp++; if (duty !== 8'd64) begin n_err++; $display("FAIL lpe_no_update: got %0d want 64", duty); end
    wait_pe(t);
    @(negedge clk);
    n_cmp++; if (duty !== 8'd74) begin n_err++; $display("FAIL lpe_next: got %0d want 74", duty); end
  endtask

  task automatic test_async_reset;
    int t;
    do_load(8'd20, 8'd10, 1'b1);
    wait_pe(t);
    @(negedge clk);
    n_cmp++; if (duty !== 8'd20) begin n_err++; $display("FAIL ar_peak: got %0d want 20", duty); end
    wait_pe(t);
    @(negedge clk);
    n_cmp++; if (duty !== 8'd10) begin n_err++; $display("FAIL ar_br_dn: got %0d want 10", duty); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (duty !== 8'd0)       begin n_err++; $display("FAIL ar_duty: got %0d want 0", duty); end
    n_cmp++; if (bus.ready !== 1'b1)  begin n_err++; $display("FAIL ar_ready: got %b want 1", bus.ready); end
    n_cmp++; if (step !== 1'b0)       begin n_err++; $display("FAIL ar_step: got %b want 0", step); end
    n_cmp++; if (period_end !== 1'b0) begin n_err++; $display("FAIL ar_pe: got %b want 0", period_end); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_prescale_shrink;
    repeat (2) @(negedge clk);
    prescale = 16'd0;
    @(negedge clk);
    n_cmp++; if (step !== 1'b0) begin n_err++; $display("FAIL shrink_wrap: got %b want 0", step); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (step !== 1'b1) begin n_err++; $display("FAIL ps0_step[%0d]: got %b want 1", i, step); end
    end
  endtask

  initial begin
    test_reset;
    test_prescale;
    test_ramp_up;
    test_ramp_down_rate0;
    test_ena_gating;
    test_breathe;
    test_load_at_pe;
    test_async_reset;
    test_prescale_shrink;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
- Sequencer that drives the `step` and `duty` inputs of one `pwm` instance.
- Generates the slow step tick from a programmable prescaler. Ramps `duty` toward a loaded target at a programmed rate, or runs a continuous triangle "breathe" between 0 and the target.
- `duty` changes only at PWM period boundaries, so a period is never split.
- Sits between the register/control layer and the `pwm` datapath.

Parameters:
- N, 8, duty width; must match the driven `pwm`. One PWM period = 2^N steps.
- PRESCALE_W, 16, width of the prescale input and the internal prescaler counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  global enable; low freezes all sequencing.
- prescale  in  PRESCALE_W  step pulses once every prescale+1 enabled clk cycles.
- load  in  1  request to accept target/rate/mode; accepted when load & ready.
- target  in  N  final duty (RAMP mode) or peak duty (BREATHE mode).
- rate  in  N  duty delta per PWM period; 0 = jump to target at the next boundary.
- mode  in  1  0 = RAMP-then-HOLD, 1 = BREATHE.
- ready  out  1  controller can accept a load.
- step  out  1  one-cycle pulse to `pwm.step`.
- duty  out  N  to `pwm.duty`; registered.
- period_end  out  1  one-cycle pulse coincident with the step that completes a PWM period.
- done  out  1  one-cycle pulse when a RAMP reaches its target.

Behaviour:
- Reset (rst low, async) sets: state IDLE, duty 0, step 0, period_end 0, done 0, ready 1, prescaler 0, step counter 0, stored target/rate/mode 0.
- Prescaler, when ena is high:
  - counts 0..prescale; at count == prescale, asserts step for one cycle and clears.
  - prescale = 0 gives step every cycle.
  - A prescale change takes effect at the next wrap. If the count already exceeds the new value, the counter wraps to 0 without a step.
- Step counter: N bits, increments on step. period_end = step & (step counter == 2^N-1). Wraps to 0.
- ena low: step, period_end and done are forced 0. Prescaler is held, not cleared. State, duty and step counter are held. load is still accepted.
- Load: on load & ready (one cycle), capture target, rate and mode.
  - mode 0: go to RAMP.
  - mode 1: go to BR_UP.
  - duty is not modified at load time.
- ready = 1 in IDLE, HOLD, BR_UP and BR_DN; 0 in RAMP. A load during a breathe aborts it. A load while ready is 0 is ignored, with no side effects.
- Duty updates happen only in the cycle period_end is high. New duty is visible the cycle after period_end.
- Arithmetic is N+1-bit with saturation; duty never wraps.
- States:
  - IDLE: duty held, no updates.
  - RAMP: if duty < target, duty = min(duty+rate, target); if duty > target, duty = max(duty-rate, target). rate 0 means duty = target. When the new duty equals target, go to HOLD and pulse done the same cycle duty updates. If duty already equals target at load, move to HOLD at the first period_end and pulse done.
  - HOLD: duty held; waits for load.
  - BR_UP: duty = min(duty+rate, target). On reaching target, go to BR_DN. rate 0 is treated as 1.
  - BR_DN: duty = max(duty-rate, 0). On reaching 0, go to BR_UP. rate 0 is treated as 1.
  - BREATHE with target 0: duty stays 0; the state alternates BR_UP/BR_DN each period.
- Loaded values above duty in BR_DN are legal: BR_DN descends from the current duty.
- A load and a period_end in the same cycle: the load wins. No duty update happens that cycle; the new state starts at the next boundary.
- Reset asserted mid-ramp: immediate return to reset values. No done pulse.

Decomposition:
- Package pwm_pkg: state enum (IDLE, RAMP, HOLD, BR_UP, BR_DN) and mode constants (MODE_RAMP = 0, MODE_BREATHE = 1).
- Sub-module pwm_tick_gen, parameterised by PRESCALE_W and N: prescaler plus step counter, producing step and period_end.
- FSM and duty arithmetic live in pwm_fade_ctrl.
- Bench instantiates pwm_fade_ctrl driving `pwm` for end-to-end checks.

Test Plan:
- Reset/prescale: release reset, ena=1, prescale=3 -> step every 4th cycle; N=8 gives period_end every 1024 cycles; duty=0, ready=1.
- Ramp up: load target=100, rate=30, mode=0 -> duty 30, 60, 90, 100 on successive period_ends; done pulses once with duty=100; state HOLD, ready=1.
- Ramp down, rate 0: from HOLD at 100, load target=10, rate=0 -> duty=10 after the first period_end; done pulses; ready low only until then.
- Breathe: load target=255, rate=64, mode=1 -> duty 64, 128, 192, 255, 191, 127, 63, 0, 64 …; no wrap past 255 or 0.
- ena gating / ignored load: ena=0 for 500 cycles mid-ramp -> no step, duty frozen, ramp resumes exactly. A load during RAMP is ignored. A load coincident with period_end performs no duty update that cycle.
- Async reset: drop rst mid-BR_DN between clock edges -> outputs go to reset values immediately, not on the next edge.
